// File: rtl/tok_pkg.sv
// Shared definitions for the character-stream lexer and its helpers.
//   state_t        : lexer FSM states (S_IDLE .. S_BAD)
//   TOK_*          : token-type codes driven on tok_type
//   CH_*           : ASCII range limits for letters, digits and underscore
//   state_to_tok() : token type reported when a token ends in a given state
package tok_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IDENT,
    S_NUMBER,
    S_BAD
  } state_t;

  localparam logic [1:0] TOK_NONE  = 2'd0;
  localparam logic [1:0] TOK_IDENT = 2'd1;
  localparam logic [1:0] TOK_NUM   = 2'd2;
  localparam logic [1:0] TOK_BAD   = 2'd3;

  localparam logic [7:0] CH_UPPER_LO = 8'd65;   // 'A'
  localparam logic [7:0] CH_UPPER_HI = 8'd90;   // 'Z'
  localparam logic [7:0] CH_LOWER_LO = 8'd97;   // 'a'
  localparam logic [7:0] CH_LOWER_HI = 8'd122;  // 'z'
  localparam logic [7:0] CH_DIGIT_LO = 8'd48;   // '0'
  localparam logic [7:0] CH_DIGIT_HI = 8'd57;   // '9'
  localparam logic [7:0] CH_US       = 8'd95;   // '_'

  function automatic logic [1:0] state_to_tok(input state_t s);
    logic [1:0] t;
    t = TOK_NONE;
    case (s)
      S_IDENT:  t = TOK_IDENT;
      S_NUMBER: t = TOK_NUM;
      S_BAD:    t = TOK_BAD;
      default:  t = TOK_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tok_scanner_char_class.sv
// char_class: combinational ASCII classifier.
//   char      in  8  character to classify
//   is_letter out 1  A-Z, a-z, and '_' when ALLOW_US != 0
//   is_digit  out 1  0-9
// Anything that is neither is a delimiter.
module char_class
  import tok_pkg::*;
#(
  parameter int ALLOW_US = 1
) (
  input  logic [7:0] char,
  output logic       is_letter,
  output logic       is_digit
);

  logic upper;
  logic lower;
  logic us;

  always_comb begin
    upper     = (char >= CH_UPPER_LO) && (char <= CH_UPPER_HI);
    lower     = (char >= CH_LOWER_LO) && (char <= CH_LOWER_HI);
    us        = (ALLOW_US != 0) && (char == CH_US);
    is_letter = upper || lower || us;
    is_digit  = (char >= CH_DIGIT_LO) && (char <= CH_DIGIT_HI);
  end

endmodule

// File: rtl/tok_scanner.sv
// tok_scanner: lexer splitting a character stream into IDENT / NUMBER / BAD
// tokens and emitting a registered descriptor one cycle after each delimiter.
//   clk, reset  : single clock, synchronous active-high reset
//   char        : input character, accepted when char_valid is high
//   flush       : end of stream, acts as a delimiter this cycle
//   tok_valid   : one-cycle pulse, descriptor below is fresh
//   tok_type    : TOK_NONE/IDENT/NUM/BAD, held until the next token
//   tok_len     : accepted characters in the token, saturated at MAX_LEN
//   tok_ovf     : token was longer than MAX_LEN
//   id_digit    : in IDENT and the last accepted character was a digit
module tok_scanner
  import tok_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int ALLOW_US = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  input  logic             flush,
  output logic             tok_valid,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_ovf,
  output logic             id_digit
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t state, state_nx, mid_state;

  logic [LEN_W-1:0] len, len_nx, mid_len;
  logic             ovf, ovf_nx, mid_ovf;
  logic             tv_nx, to_nx, id_nx;
  logic [1:0]       tt_nx;
  logic [LEN_W-1:0] tl_nx;

  logic is_letter;
  logic is_digit;
  logic tok_char;
  logic end_tok;

  char_class #(
    .ALLOW_US(ALLOW_US)
  ) u_class (
    .char     (char),
    .is_letter(is_letter),
    .is_digit (is_digit)
  );

  // The character (if any) is folded into the token first (mid_*), then a
  // delimiter or flush closes whatever token that leaves. This lets flush
  // with a valid letter/digit append that char before emitting.
  always_comb begin
    state_nx  = state;
    len_nx    = len;
    ovf_nx    = ovf;
    tv_nx     = 1'b0;
    tt_nx     = tok_type;
    tl_nx     = tok_len;
    to_nx     = tok_ovf;
    id_nx     = id_digit;
    mid_state = state;
    mid_len   = len;
    mid_ovf   = ovf;

    tok_char = char_valid && (is_letter || is_digit);
    end_tok  = flush || (char_valid && !tok_char);

    if (tok_char) begin
      if (state == S_IDLE) begin
        mid_state = is_letter ? S_IDENT : S_NUMBER;
        mid_len   = LEN_ONE;
        mid_ovf   = 1'b0;
      end else begin
        if ((state == S_NUMBER) && is_letter) begin
          mid_state = S_BAD;
        end
        if (len == LEN_MAX) begin
          mid_ovf = 1'b1;
        end else begin
          mid_len = len + LEN_ONE;
        end
      end
      id_nx = (state == S_IDENT) && is_digit;
    end

    if (end_tok) begin
      id_nx    = 1'b0;
      state_nx = S_IDLE;
      len_nx   = '0;
      ovf_nx   = 1'b0;
      if (mid_state != S_IDLE) begin
        tv_nx = 1'b1;
        tt_nx = state_to_tok(mid_state);
        tl_nx = mid_len;
        to_nx = mid_ovf;
      end
    end else begin
      state_nx = mid_state;
      len_nx   = mid_len;
      ovf_nx   = mid_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      ovf       <= 1'b0;
      tok_valid <= 1'b0;
      tok_type  <= TOK_NONE;
      tok_len   <= '0;
      tok_ovf   <= 1'b0;
      id_digit  <= 1'b0;
    end else begin
      state     <= state_nx;
      len       <= len_nx;
      ovf       <= ovf_nx;
      tok_valid <= tv_nx;
      tok_type  <= tt_nx;
      tok_len   <= tl_nx;
      tok_ovf   <= to_nx;
      id_digit  <= id_nx;
    end
  end

endmodule

// File: tb/tb_tok_scanner.sv
module tb_tok_scanner;

  logic       clk;
  logic       reset;
  logic [7:0] char;
  logic       char_valid;
  logic       flush;

  logic       tv0, to0, id0;
  logic [1:0] tt0;
  logic [4:0] tl0;
  logic       tv1, to1, id1;
  logic [1:0] tt1;
  logic [2:0] tl1;

  int errors = 0;
  int checks = 0;

  tok_scanner u_dut0 (
    .clk(clk), .reset(reset), .char(char), .char_valid(char_valid), .flush(flush),
    .tok_valid(tv0), .tok_type(tt0), .tok_len(tl0), .tok_ovf(to0), .id_digit(id0)
  );

  tok_scanner #(
    .MAX_LEN(4),
    .ALLOW_US(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .char(char), .char_valid(char_valid), .flush(flush),
    .tok_valid(tv1), .tok_type(tt1), .tok_len(tl1), .tok_ovf(to1), .id_digit(id1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a token is a maximal run of letters/digits. It is an
  // IDENT if it starts with a letter, a NUMBER if all digits, BAD otherwise.
  int         m_n[2];
  logic [7:0] m_first[2];
  bit         m_alldig[2];
  bit         m_lastdig[2];
  logic       e_tv[2];
  logic [1:0] e_tt[2];
  int         e_tl[2];
  logic       e_to[2];
  logic       e_id[2];

  function automatic bit is_l(input logic [7:0] c, input bit us);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122) || (us && c == 8'd95);
  endfunction

  function automatic bit is_d(input logic [7:0] c);
    return c >= 8'd48 && c <= 8'd57;
  endfunction

  task automatic model_step(input int k, input int maxl, input bit us,
                            input logic [7:0] c, input bit v, input bit f, input bit r);
    bit tokc;
    bit ended;
    e_tv[k] = 1'b0;
    if (r) begin
      m_n[k] = 0;
      e_tt[k] = 2'd0; e_tl[k] = 0; e_to[k] = 1'b0; e_id[k] = 1'b0;
      return;
    end
    tokc = v && (is_l(c, us) || is_d(c));
    if (tokc) begin
      if (m_n[k] == 0) begin
        m_first[k]  = c;
        m_alldig[k] = 1'b1;
      end
      m_n[k]++;
      if (!is_d(c)) m_alldig[k] = 1'b0;
      m_lastdig[k] = is_d(c);
    end
    ended = f || (v && !tokc);
    if (ended && m_n[k] > 0) begin
      e_tv[k] = 1'b1;
      e_tt[k] = is_l(m_first[k], us) ? 2'd1 : (m_alldig[k] ? 2'd2 : 2'd3);
      e_tl[k] = (m_n[k] > maxl) ? maxl : m_n[k];
      e_to[k] = (m_n[k] > maxl);
    end
    if (ended) m_n[k] = 0;
    e_id[k] = (m_n[k] > 0) && is_l(m_first[k], us) && m_lastdig[k];
  endtask

  task automatic cyc(input logic [7:0] c, input bit v, input bit f, input bit r);
    char = c; char_valid = v; flush = f; reset = r;
    @(posedge clk);
    model_step(0, 16, 1'b1, c, v, f, r);
    model_step(1, 4, 1'b0, c, v, f, r);
    #1;
    check("tv0", 32'(tv0), 32'(e_tv[0]));
    check("tt0", 32'(tt0), 32'(e_tt[0]));
    check("tl0", 32'(tl0), 32'(e_tl[0]));
    check("to0", 32'(to0), 32'(e_to[0]));
    check("id0", 32'(id0), 32'(e_id[0]));
    check("tv1", 32'(tv1), 32'(e_tv[1]));
    check("tt1", 32'(tt1), 32'(e_tt[1]));
    check("tl1", 32'(tl1), 32'(e_tl[1]));
    check("to1", 32'(to1), 32'(e_to[1]));
    check("id1", 32'(id1), 32'(e_id[1]));
  endtask

  task automatic send(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      cyc(c, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] rand_char(input int delim_pct);
    int r;
    r = $urandom_range(0, 99);
    if (r < delim_pct) return ($urandom_range(0, 1) != 0) ? 8'd32 : 8'($urandom_range(0, 255));
    r = $urandom_range(0, 99);
    if (r < 40) return 8'($urandom_range(97, 122));
    if (r < 55) return 8'($urandom_range(65, 90));
    if (r < 90) return 8'($urandom_range(48, 57));
    return 8'd95;
  endfunction

  initial begin
    char = '0; char_valid = 1'b0; flush = 1'b0; reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_first[k] = '0; m_alldig[k] = 1'b0; m_lastdig[k] = 1'b0;
    end
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_tv", 32'(tv0), 0);
    check("rst_len", 32'(tl0), 0);

    // "ab1 "
    send("ab1");
    check("ab1_id", 32'(id0), 1);
    send(" ");
    check("ab1_tv", 32'(tv0), 1);
    check("ab1_type", 32'(tt0), 1);
    check("ab1_len", 32'(tl0), 3);
    check("ab1_ovf", 32'(to0), 0);
    idle(1);
    check("ab1_pulse", 32'(tv0), 0);

    // "123;" then "12ab\n", and a delimiter while idle
    send("123;");
    check("num_type", 32'(tt0), 2);
    check("num_len", 32'(tl0), 3);
    send("12ab\n");
    check("bad_type", 32'(tt0), 3);
    check("bad_len", 32'(tl0), 4);
    send(";");
    check("idle_delim", 32'(tv0), 0);

    // saturation on the MAX_LEN=4 instance, ovf cleared for the next token
    send("abcdef ");
    check("sat_len", 32'(tl1), 4);
    check("sat_ovf", 32'(to1), 1);
    send("x ");
    check("sat_next_len", 32'(tl1), 1);
    check("sat_next_ovf", 32'(to1), 0);

    // underscore handling
    send("a_");
    check("us1_tv", 32'(tv1), 1);
    check("us1_len", 32'(tl1), 1);
    send("9 ");
    check("us0_type", 32'(tt0), 1);
    check("us0_len", 32'(tl0), 3);
    check("us1_type", 32'(tt1), 2);

    // reset mid-token discards the partial token
    send("ab");
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    check("rstmid_type", 32'(tt0), 0);
    check("rstmid_id", 32'(id0), 0);
    send(" ");
    check("rstmid_tv", 32'(tv0), 0);

    // gaps, then flush with a valid letter
    send("7");
    idle(3);
    send("x");
    idle(3);
    cyc("y", 1'b1, 1'b1, 1'b0);
    check("flush_tv", 32'(tv0), 1);
    check("flush_type", 32'(tt0), 3);
    check("flush_len", 32'(tl0), 3);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    check("flush_idle", 32'(tv0), 0);

    // randomized traffic: dense delimiters, then long runs for saturation
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 3000; i++) begin
        cyc(rand_char(ph == 0 ? 25 : 3),
            $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < (ph == 0 ? 4 : 1),
            $urandom_range(0, 199) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tok_scanner.md
Name: tok_scanner

Overview:
- Parametrised character-stream lexer; the next generation of the single-pattern identifier detector.
- Consumes one 8-bit ASCII character per accepted cycle and classifies runs of characters as IDENT (a letter followed by letters/digits), NUMBER (digits only) or BAD (digits followed by a letter).
- On each delimiter it emits a registered token descriptor (type, length, overflow).
- Sits between the UART/byte source and the parser front end.

Parameters:
- MAX_LEN, 16, saturation limit of the token length counter (must be ≥1).
- LEN_W, $clog2(MAX_LEN+1), width of tok_len (derived; do not override).
- ALLOW_US, 1, when 1 the underscore '_' (95) is classified as a letter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- char  in  8  input character.
- char_valid  in  1  char is accepted this cycle when high.
- flush  in  1  end-of-stream; treated as a delimiter in the same cycle, regardless of char.
- tok_valid  out  1  one-cycle pulse: the token descriptor is valid.
- tok_type  out  2  0 NONE, 1 IDENT, 2 NUMBER, 3 BAD.
- tok_len  out  LEN_W  accepted characters in the token, saturated at MAX_LEN.
- tok_ovf  out  1  token length exceeded MAX_LEN.
- id_digit  out  1  high while in IDENT and the last accepted char was a digit.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset).
- Character classes:
  - LETTER: 65–90, 97–122, and 95 if ALLOW_US.
  - DIGIT: 48–57.
  - DELIM: everything else.
- States: IDLE, IDENT, NUMBER, BAD.
- Reset: state=IDLE, len=0, ovf=0; tok_valid=0, tok_type=0, tok_len=0, tok_ovf=0, id_digit=0.
- No char_valid and no flush: state, counter and all outputs hold, except tok_valid, which drops to 0.
- Transitions on an accepted char:
  - IDLE: LETTER→IDENT; DIGIT→NUMBER; DELIM→IDLE with no token.
  - IDENT: LETTER or DIGIT→IDENT; DELIM→emit IDENT, go to IDLE.
  - NUMBER: DIGIT→NUMBER; LETTER→BAD; DELIM→emit NUMBER, go to IDLE.
  - BAD: LETTER or DIGIT→BAD; DELIM→emit BAD, go to IDLE.
- Length counter:
  - Entering a token from IDLE sets len=1.
  - Each further non-delimiter char gives len=min(len+1, MAX_LEN).
  - Attempting to increment past MAX_LEN sets sticky ovf for the current token.
  - The delimiter itself is not counted.
- Emission:
  - tok_valid=1 on the cycle after the delimiter or flush edge, with tok_type, tok_len and tok_ovf registered from the token that just ended.
  - len and ovf clear in that same edge.
  - tok_type, tok_len and tok_ovf hold their values until the next emission.
- Flush:
  - Treated as a delimiter. If char_valid is also high with a non-delimiter char, that char is first appended to the token, then the token is emitted.
  - Flush in IDLE: no token.
- id_digit: registered. Set when an accepted DIGIT keeps the FSM in IDENT; cleared on an accepted LETTER, on a delimiter, or on reset.
- Back-to-back tokens: "a b" gives two tokens. The next token may start on the cycle right after the delimiter, while tok_valid for the previous token is high.
- Reset mid-token: the partial token is discarded; no tok_valid ever appears for it.
- Reset has priority over char_valid and flush in the same cycle.
- Latency: exactly 1 cycle from the accepting edge of the delimiter to tok_valid.

Decomposition:
- Shared package tok_pkg holds:
  - state encodings S_IDLE..S_BAD;
  - token-type constants TOK_NONE, TOK_IDENT, TOK_NUM, TOK_BAD;
  - ASCII range constants for letters, digits and underscore.
- One combinational sub-module, char_class (char, ALLOW_US → is_letter, is_digit), reused later by the parser.
- The counter and FSM stay in tok_scanner.

Test Plan:
- "ab1 " at 1 char/cycle: id_digit=1 after '1'; tok_valid one cycle after ' ' with type=1, len=3, ovf=0.
- "123;" then "12ab\n": first token type=2, len=3; second token type=3, len=4; no token for ';' or '\n' while in IDLE.
- MAX_LEN=4, "abcdef ": type=1, len=4, ovf=1. The next token "x " gives len=1, ovf=0 (ovf cleared).
- "a_9 " with ALLOW_US=1 → IDENT, len=3. With ALLOW_US=0 → IDENT len=1, then NUMBER len=1 ('_' acts as the delimiter).
- "ab", reset for 1 cycle, then " ": no tok_valid at any point; all outputs are 0 after reset.
- "7x" with char_valid gaps of 3 cycles, then flush=1 with char='y' valid: a single tok_valid, type=3, len=3; outputs hold during the gaps.
